// File: rtl/sma_acc_signed.sv
// Signed product accumulator: sums N_TERMS consecutive 8-bit products into an
// ACC_W-bit result and hands it off through a buffered valid/ready register.
// Optional feature: define SMA_ACC_SAT_EN to saturate each add and flag it on
// out_ovf; otherwise adds wrap and out_ovf is always 0.
module sma_acc_signed #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;

  logic             first_term;
  logic             last_term;
  logic             accept;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             ovf_next;

  assign first_term = (cnt == '0);
  assign last_term  = (cnt == LAST_CNT);

  // Stall only when the final term would overwrite an undrained result.
  assign in_ready = !(last_term && out_valid && !out_ready);
  assign accept   = in_valid && in_ready && !clr;

  assign ext  = ACC_W'($signed(in_p));
  assign base = first_term ? '0 : acc;

`ifdef SMA_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;

  // Saturating add: one guard bit exposes signed overflow of the ACC_W-bit sum.
  always_comb begin
    wide    = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
    add_ovf = 1'b0;
    sum     = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      add_ovf = 1'b1;
      sum     = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  // Wrapping add modulo 2^ACC_W; no overflow is ever reported.
  always_comb begin
    sum     = base + ext;
    add_ovf = 1'b0;
  end
`endif

  assign ovf_next = (first_term ? 1'b0 : ovf_pend) | add_ovf;

  // Partial-sum state; clr wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else if (accept) begin
      acc      <= sum;
      ovf_pend <= ovf_next;
      cnt      <= last_term ? '0 : cnt + CNT_W'(1);
    end
  end

  // Output register: load on the final term, otherwise clear on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (accept && last_term) begin
      out_valid <= 1'b1;
      out_acc   <= sum;
      out_ovf   <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
